// File: rtl/fp_unit_scheduler_pkg.sv
// fp_unit_scheduler_pkg: op codes, FSM encoding and constants shared by the FP unit scheduler.
package fp_unit_scheduler_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_F2I = 3'd4;
    localparam logic [2:0] OP_I2F = 3'd5;
    localparam logic [2:0] OP_MAX = 3'd5;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/fp_unit_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        // Lowest set bit overall is the wrap-around fallback; lowest at/after the pointer overrides it.
        for (int j = N - 1; j >= 0; j--) if (i_req[j]) o_idx = IW'(j);
        for (int j = N - 1; j >= 0; j--) if (i_req[j] && IW'(j) >= i_ptr) o_idx = IW'(j);
        o_grant = o_any ? (N'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/fp_unit_scheduler.sv
// fp_unit_scheduler: round-robin sharing of one FP unit between NUM_REQ requesters,
// latching operands at grant and returning a one-cycle response pulse.
module fp_unit_scheduler
    import fp_unit_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [3*NUM_REQ-1:0]  i_req_op,
    input  logic [32*NUM_REQ-1:0] i_req_dataa,
    input  logic [32*NUM_REQ-1:0] i_req_datab,
    output logic [NUM_REQ-1:0]    o_resp_valid,
    output logic [31:0]           o_resp_result,
    output logic                  o_resp_err,
    output logic                  o_busy,
    output logic [2:0]            o_fp_operation,
    output logic [31:0]           o_fp_dataa,
    output logic [31:0]           o_fp_datab,
    output logic                  o_fp_clk_en,
    input  logic [31:0]           i_fp_result,
    input  logic                  i_fp_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t               r_state, w_next;
    logic [IW-1:0]        r_ptr, r_idx, w_idx;
    logic [NUM_REQ-1:0]   r_grant, w_grant;
    logic                 w_any, w_bad, w_timeout, r_err;
    logic [2:0]           r_op, w_op;
    logic [31:0]          r_a, r_b, r_result;
    logic [CW-1:0]        r_cnt;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_op      = i_req_op[3*w_idx +: 3];
    assign w_bad     = w_op > OP_MAX;
    assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);

    // Clock enable decodes straight from state so an async reset drops it at once.
    assign o_fp_clk_en    = r_state == S_WAIT;
    assign o_busy         = r_state != S_IDLE;
    assign o_resp_valid   = (r_state == S_RESP) ? r_grant : '0;
    assign o_resp_result  = (r_state == S_RESP) ? r_result : '0;
    assign o_resp_err     = (r_state == S_RESP) && r_err;
    assign o_fp_operation = r_op;
    assign o_fp_dataa     = r_a;
    assign o_fp_datab     = r_b;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = w_bad ? S_RESP : S_WAIT;
            S_WAIT:  if (i_fp_done || w_timeout) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_grant  <= '0;
            r_err    <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_any) begin
                r_idx    <= w_idx;
                r_grant  <= w_grant;
                r_cnt    <= '0;
                r_err    <= w_bad;
                r_result <= '0;
                // Invalid ops never reach the FP unit, so its inputs keep their last values.
                if (!w_bad) begin
                    r_op <= w_op;
                    r_a  <= i_req_dataa[32*w_idx +: 32];
                    r_b  <= i_req_datab[32*w_idx +: 32];
                end
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
                if (i_fp_done) r_result <= i_fp_result;
                else if (w_timeout) begin
                    r_result <= FP_QNAN;
                    r_err    <= 1'b1;
                end
            end
            if (r_state == S_RESP) r_ptr <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);
        end
    end
endmodule
